// File: rtl/reg_writeback_queue.sv
// Writeback queue: arbitrates ALU/load results into a small FIFO that drains into the
// register file write port, and keeps a per-register busy scoreboard. Optional macro: WBQ_BYPASS_EN.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic        wb_stall,
  output logic        RegWre,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic [31:0] busy,
  output logic        wbq_empty
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {GNT_ALU, GNT_MEM} grant_e;

  grant_e        lastGrant;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];

  logic        aluCand, memCand, notFull;
  logic        aluXfer, memXfer, anyXfer;
  logic [4:0]  xferReg;
  logic [31:0] xferData;
  logic        push, pop, bypass;
  logic [31:0] busyNext;

  // Round-robin: on a tie the source that lost the previous transfer wins.
  assign aluCand = alu_valid && (!mem_valid || lastGrant == GNT_MEM);
  assign memCand = mem_valid && (!alu_valid || lastGrant == GNT_ALU);
  assign notFull = count < (AW+1)'(DEPTH);

  assign alu_ready = !Reset && aluCand && notFull;
  assign mem_ready = !Reset && memCand && notFull;
  assign aluXfer   = alu_valid && alu_ready;
  assign memXfer   = mem_valid && mem_ready;
  assign anyXfer   = aluXfer || memXfer;
  assign xferReg   = aluXfer ? alu_reg  : mem_reg;
  assign xferData  = aluXfer ? alu_data : mem_data;

  assign wbq_empty = (count == '0);
  assign pop       = !wbq_empty && !wb_stall;

`ifdef WBQ_BYPASS_EN
  assign bypass = anyXfer && (xferReg != 5'd0) && wbq_empty && !wb_stall;
`else
  assign bypass = 1'b0;
`endif

  // Writes to register 0 are accepted but never stored.
  assign push = anyXfer && (xferReg != 5'd0) && !bypass;

  always_comb begin
    RegWre    = pop || bypass;
    WriteReg  = 5'd0;
    WriteData = 32'd0;
    if (pop) begin
      WriteReg  = regMem[rdPtr];
      WriteData = dataMem[rdPtr];
    end else if (bypass) begin
      WriteReg  = xferReg;
      WriteData = xferData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      lastGrant <= GNT_MEM;
    end else begin
      if (anyXfer) lastGrant <= aluXfer ? GNT_ALU : GNT_MEM;
      if (push)    wrPtr     <= wrPtr + 1'b1;
      if (pop)     rdPtr     <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the empty count guarantees stale entries are never read.
  always_ff @(posedge CLK) begin
    if (push) begin
      regMem[wrPtr]  <= xferReg;
      dataMem[wrPtr] <= xferData;
    end
  end

  // NOTE: default assignment first so the combinational block cannot infer a latch.
  always_comb begin
    busyNext = busy;
    if (RegWre)      busyNext[WriteReg]  = 1'b0;
    if (issue_valid) busyNext[issue_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) busy <= '0;
    else       busy <= busyNext;
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed self-checking bench for reg_writeback_queue (default build, DEPTH = 4).
module tb_reg_writeback_queue;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        alu_valid, mem_valid, issue_valid, wb_stall;
  logic [4:0]  alu_reg, mem_reg, issue_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, RegWre, wbq_empty;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, busy;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 CLK = ~CLK;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .wb_stall(wb_stall),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy(busy), .wbq_empty(wbq_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    issue_valid = 0; issue_reg = 0;
  endtask

  task automatic expWrite(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, "_wre"},  {31'd0, RegWre}, 32'd1);
    check({tag, "_reg"},  {27'd0, WriteReg}, {27'd0, r});
    check({tag, "_data"}, WriteData, d);
  endtask

  initial begin
    Reset = 1; wb_stall = 0;
    idle();
    alu_valid = 1; alu_reg = 5'd3;
    #2;
    check("rst_wre",   {31'd0, RegWre}, 32'd0);
    check("rst_wreg",  {27'd0, WriteReg}, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_empty", {31'd0, wbq_empty}, 32'd1);
    check("rst_busy",  busy, 32'd0);
    check("rst_aready", {31'd0, alu_ready}, 32'd0);
    idle();
    cyc(); Reset = 0;

    // Single ALU write: one cycle of latency, exactly one write.
    cyc(); alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("t1_ready", {31'd0, alu_ready}, 32'd1);
    check("t1_nowre", {31'd0, RegWre}, 32'd0);
    cyc(); idle(); #1;
    expWrite("t1_wr", 5'd5, 32'hDEADBEEF);
    check("t1_nempty", {31'd0, wbq_empty}, 32'd0);
    cyc(); #1;
    check("t1_once", {31'd0, RegWre}, 32'd0);
    check("t1_empty", {31'd0, wbq_empty}, 32'd1);

    // Load to register 0: accepted, dropped. Leaves the last grant with mem.
    mem_valid = 1; mem_reg = 5'd0; mem_data = 32'h12345678;
    #1;
    check("r0_ready", {31'd0, mem_ready}, 32'd1);
    cyc(); idle(); #1;
    check("r0_nowre", {31'd0, RegWre}, 32'd0);
    check("r0_empty", {31'd0, wbq_empty}, 32'd1);

    // Both sources valid: grants alternate alu, mem, alu, mem.
    alu_valid = 1; alu_reg = 5'd1; alu_data = 32'h101;
    mem_valid = 1; mem_reg = 5'd2; mem_data = 32'h102;
    #1;
    check("rr1_alu", {31'd0, alu_ready}, 32'd1);
    check("rr1_mem", {31'd0, mem_ready}, 32'd0);
    cyc(); alu_reg = 5'd3; alu_data = 32'h103; #1;
    check("rr2_alu", {31'd0, alu_ready}, 32'd0);
    check("rr2_mem", {31'd0, mem_ready}, 32'd1);
    expWrite("rr2_wr", 5'd1, 32'h101);
    cyc(); mem_reg = 5'd4; mem_data = 32'h104; #1;
    check("rr3_alu", {31'd0, alu_ready}, 32'd1);
    check("rr3_mem", {31'd0, mem_ready}, 32'd0);
    expWrite("rr3_wr", 5'd2, 32'h102);
    cyc(); alu_reg = 5'd5; alu_data = 32'h105; #1;
    check("rr4_alu", {31'd0, alu_ready}, 32'd0);
    check("rr4_mem", {31'd0, mem_ready}, 32'd1);
    expWrite("rr4_wr", 5'd3, 32'h103);
    cyc(); idle(); #1;
    expWrite("rr5_wr", 5'd4, 32'h104);
    cyc(); #1;
    check("rr6_empty", {31'd0, wbq_empty}, 32'd1);

    // Stalled fill: four accepted, fifth held until a pop frees a slot.
    wb_stall = 1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_reg = 5'(9 + i); alu_data = 32'hA00 + 32'(i);
      #1;
      check("st_ready", {31'd0, alu_ready}, 32'd1);
      check("st_nowre", {31'd0, RegWre}, 32'd0);
      cyc();
    end
    alu_reg = 5'd13; alu_data = 32'hA04;
    #1;
    check("st_full_ready", {31'd0, alu_ready}, 32'd0);
    check("st_full_wre",   {31'd0, RegWre}, 32'd0);
    cyc(); wb_stall = 0; #1;
    check("st_pop_ready", {31'd0, alu_ready}, 32'd0);
    expWrite("st_w0", 5'd9, 32'hA00);
    cyc(); #1;
    check("st_5th_ready", {31'd0, alu_ready}, 32'd1);
    expWrite("st_w1", 5'd10, 32'hA01);
    cyc(); idle(); #1;
    expWrite("st_w2", 5'd11, 32'hA02);
    cyc(); #1;
    expWrite("st_w3", 5'd12, 32'hA03);
    cyc(); #1;
    expWrite("st_w4", 5'd13, 32'hA04);
    cyc(); #1;
    check("st_empty", {31'd0, wbq_empty}, 32'd1);

    // Scoreboard: set on issue, clear on write, set wins on collision, r0 ignored.
    issue_valid = 1; issue_reg = 5'd7; #1;
    check("sb_pre", busy, 32'd0);
    cyc(); idle(); #1;
    check("sb_set", busy, 32'h80);
    alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h77;
    cyc(); idle(); #1;
    expWrite("sb_wr", 5'd7, 32'h77);
    check("sb_held", busy, 32'h80);
    cyc(); #1;
    check("sb_clr", busy, 32'd0);
    issue_valid = 1; issue_reg = 5'd0;
    cyc(); idle(); #1;
    check("sb_r0", busy, 32'd0);
    issue_valid = 1; issue_reg = 5'd7;
    cyc(); idle(); alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h78;
    cyc(); idle(); issue_valid = 1; issue_reg = 5'd7; #1;
    expWrite("sb_coll_wr", 5'd7, 32'h78);
    cyc(); idle(); #1;
    check("sb_setwins", busy, 32'h80);

    // Reset mid-operation with three queued entries and busy = 0xF0.
    wb_stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_reg = 5'(20 + i); alu_data = 32'hC0 + 32'(i);
      issue_valid = 1; issue_reg = 5'(4 + i);
      cyc();
    end
    idle(); #1;
    check("mr_busy",  busy, 32'hF0);
    check("mr_empty", {31'd0, wbq_empty}, 32'd0);
    wb_stall = 0; Reset = 1; #1;
    check("mr_wre",   {31'd0, RegWre}, 32'd0);
    check("mr_wreg",  {27'd0, WriteReg}, 32'd0);
    check("mr_wdata", WriteData, 32'd0);
    check("mr_busy0", busy, 32'd0);
    check("mr_empty1", {31'd0, wbq_empty}, 32'd1);
    cyc(); Reset = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mr_nowrite", {31'd0, RegWre}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
